// File: rtl/riscv_trace_pkg.sv
// -----------------------------------------------------------------------------
// riscv_trace_pkg
// Shared definitions for the RISC-V EX-stage trace buffer:
//   - trace_state_t : capture FSM encoding (IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3)
//   - FLAG_*        : bit positions inside the 6-bit flag field
//   - trace_entry_t : one 70-bit FIFO entry {pc, alu, flags}
//   - pack_flags    : builds the flag field from the pipeline side signals
//   - sat_inc16     : saturating 16-bit increment for the event counters
// -----------------------------------------------------------------------------
package riscv_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FROZEN  = 2'd3
    } trace_state_t;

    localparam int FLAG_W        = 6;
    localparam int ENTRY_W       = 70;
    localparam int FLAG_PCSRC    = 5;
    localparam int FLAG_STALL    = 4;
    localparam int FLAG_FWDA_LSB = 2;
    localparam int FLAG_FWDB_LSB = 0;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       alu;
        logic [FLAG_W-1:0] flags;
    } trace_entry_t;

    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic       pcsrc,
        input logic       stall,
        input logic [1:0] fwd_a,
        input logic [1:0] fwd_b
    );
        logic [FLAG_W-1:0] f;
        f                                 = '0;
        f[FLAG_PCSRC]                     = pcsrc;
        f[FLAG_STALL]                     = stall;
        f[FLAG_FWDA_LSB+1:FLAG_FWDA_LSB]  = fwd_a;
        f[FLAG_FWDB_LSB+1:FLAG_FWDB_LSB]  = fwd_b;
        return f;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/riscv_trace_buffer_if.sv
// -----------------------------------------------------------------------------
// riscv_trace_buffer_if
// Valid/ready stream carrying the head entry of the trace FIFO to a consumer.
//   trc_valid  : head entry available (producer -> consumer)
//   trc_ready  : consumer accepts the head entry this cycle
//   trc_pc     : head entry PC
//   trc_alu    : head entry ALU result
//   trc_flags  : head entry {PCSrc, pipeline_stall, forwardA, forwardB}
// master = trace buffer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface riscv_trace_buffer_if;

    logic        trc_valid;
    logic        trc_ready;
    logic [31:0] trc_pc;
    logic [31:0] trc_alu;
    logic [5:0]  trc_flags;

    modport master (
        output trc_valid, trc_pc, trc_alu, trc_flags,
        input  trc_ready
    );

    modport slave (
        input  trc_valid, trc_pc, trc_alu, trc_flags,
        output trc_ready
    );

endinterface

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// DEPTH x 70-bit FIFO with a registered head entry.
//   clk, reset : clock, synchronous active-low reset
//   push       : write wdata (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   wdata      : entry to write
//   head       : registered head entry, zero after reset
//   count      : occupancy 0..DEPTH
// A word written at edge N reaches head only from edge N onward (no bypass
// from wdata to head in the same cycle).
// -----------------------------------------------------------------------------
module trace_fifo
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  trace_entry_t wdata,
    output trace_entry_t head,
    output logic [4:0]   count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

    trace_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_n;
    logic          push_ok;
    logic          pop_ok;
    logic [4:0]    count_n;
    trace_entry_t  head_n;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        push_ok  = push && (count != DEPTH_C);
        pop_ok   = pop && (count != 5'd0);
        rd_ptr_n = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
        count_n  = count + 5'(push_ok) - 5'(pop_ok);
        head_n   = head;
        // The slot that becomes head is either being written right now
        // (FIFO empty, or emptied by this pop) or already sits in memory.
        if (push_ok && (wr_ptr == rd_ptr_n)) begin
            head_n = wdata;
        end else if (pop_ok && (count_n != 5'd0)) begin
            head_n = mem[rd_ptr_n];
        end
    end

    // NOTE: the storage array has no reset; occupancy and pointers decide
    // what is valid, and leaving it unreset keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            head   <= head_n;
        end
    end

endmodule

// File: rtl/riscv_trace_buffer.sv
// -----------------------------------------------------------------------------
// riscv_trace_buffer
// Triggered capture of EX-stage trace samples into a FIFO.
//   clk, reset          : clock, synchronous active-low reset
//   arm                 : 1 = enable trigger/capture, 0 = return to IDLE
//   trig_pc             : PC value that starts capture
//   PC_EX, ALU_OUT_EX   : EX-stage PC and ALU result
//   PCSrc               : branch/jump taken
//   pipeline_stall      : stalled cycles are never sampled
//   forwardA, forwardB  : forwarding mux selects
//   trc                 : head-entry stream (valid/ready), master side
//   state               : IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3
//   count               : FIFO occupancy
//   stall_count         : stalled cycles seen in CAPTURE (saturating)
//   branch_count        : taken-branch samples seen in CAPTURE (saturating)
// -----------------------------------------------------------------------------
module riscv_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic [31:0] trig_pc,
    input  logic [31:0] PC_EX,
    input  logic [31:0] ALU_OUT_EX,
    input  logic        PCSrc,
    input  logic        pipeline_stall,
    input  logic [1:0]  forwardA,
    input  logic [1:0]  forwardB,
    riscv_trace_buffer_if.master trc,
    output logic [1:0]  state,
    output logic [4:0]  count,
    output logic [15:0] stall_count,
    output logic [15:0] branch_count
);

    localparam logic [4:0] DEPTH_C   = 5'(DEPTH);
    localparam logic [4:0] DEPTH_M1  = 5'(DEPTH - 1);

    trace_state_t state_q;
    trace_entry_t wdata;
    trace_entry_t head;
    logic         sample;
    logic         full;
    logic         trigger;
    logic         push;
    logic         pop;
    logic         fills;

    always_comb begin
        sample  = !pipeline_stall;
        full    = (count == DEPTH_C);
        pop     = trc.trc_ready && (count != 5'd0);
        trigger = arm && sample && (state_q == ARMED) && (PC_EX == trig_pc);
        push    = !full && (trigger || (arm && sample && (state_q == CAPTURE)));
        // This write takes the FIFO to DEPTH: the capture window closes on it.
        fills   = push && !pop && (count == DEPTH_M1);
        wdata   = '{pc:    PC_EX,
                    alu:   ALU_OUT_EX,
                    flags: pack_flags(PCSrc, pipeline_stall, forwardA, forwardB)};
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            stall_count  <= '0;
            branch_count <= '0;
        end else if (!arm) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q      <= ARMED;
                    stall_count  <= '0;
                    branch_count <= '0;
                end
                ARMED: begin
                    // A re-arm on a full FIFO has nowhere to put the trigger
                    // sample, so the window is closed immediately.
                    if (trigger) begin
                        state_q <= (full || fills) ? FROZEN : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (fills) begin
                        state_q <= FROZEN;
                    end
                    if (pipeline_stall) begin
                        stall_count <= sat_inc16(stall_count);
                    end
                    if (sample && PCSrc) begin
                        branch_count <= sat_inc16(branch_count);
                    end
                end
                FROZEN: begin
                    state_q <= FROZEN;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign state         = state_q;
    assign trc.trc_valid = (count != 5'd0);
    assign trc.trc_pc    = head.pc;
    assign trc.trc_alu   = head.alu;
    assign trc.trc_flags = head.flags;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_riscv_trace_buffer
// Directed, self-checking bench for riscv_trace_buffer (DEPTH = 8).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_riscv_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic [31:0] trig_pc;
    logic [31:0] pc_ex;
    logic [31:0] alu_ex;
    logic        pcsrc;
    logic        stall;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [1:0]  state;
    logic [4:0]  count;
    logic [15:0] stall_count;
    logic [15:0] branch_count;

    int checks = 0;
    int passed = 0;

    riscv_trace_buffer_if bus ();

    riscv_trace_buffer #(
        .DEPTH (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .arm            (arm),
        .trig_pc        (trig_pc),
        .PC_EX          (pc_ex),
        .ALU_OUT_EX     (alu_ex),
        .PCSrc          (pcsrc),
        .pipeline_stall (stall),
        .forwardA       (fwd_a),
        .forwardB       (fwd_b),
        .trc            (bus),
        .state          (state),
        .count          (count),
        .stall_count    (stall_count),
        .branch_count   (branch_count)
    );

    always #5 clk = ~clk;

    // ALU stimulus derived from the PC so every entry carries a distinct value.
    function automatic logic [31:0] alu_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        pc_ex  = pc;
        alu_ex = alu_of(pc);
    endtask

    task automatic test_reset();
        reset = 1'b0; arm = 1'b0; trig_pc = 32'h10; stall = 1'b0;
        pcsrc = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00; bus.trc_ready = 1'b0;
        set_pc(32'h0);
        step(); step();
        checks++; if (state !== 2'd0 || count !== 5'd0 || bus.trc_valid !== 1'b0)
            $display("FAIL reset_ctl state=%0d count=%0d valid=%b exp 0/0/0", state, count, bus.trc_valid);
        else passed++;
        checks++; if (bus.trc_pc !== 32'h0 || bus.trc_alu !== 32'h0 || bus.trc_flags !== 6'h0)
            $display("FAIL reset_head pc=%h alu=%h flags=%b exp zeros", bus.trc_pc, bus.trc_alu, bus.trc_flags);
        else passed++;
        checks++; if (stall_count !== 16'd0 || branch_count !== 16'd0)
            $display("FAIL reset_cnt stall=%0d branch=%0d exp 0/0", stall_count, branch_count);
        else passed++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_trigger();
        arm = 1'b1; trig_pc = 32'h10;
        set_pc(32'h00); step();
        for (int i = 1; i < 4; i++) begin
            set_pc(32'(4 * i)); step();
            checks++; if (state !== 2'd1 || count !== 5'd0)
                $display("FAIL trig_armed pc=%h state=%0d count=%0d exp 1/0", pc_ex, state, count);
            else passed++;
        end
        set_pc(32'h10); step();
        checks++; if (state !== 2'd2 || count !== 5'd1 || bus.trc_valid !== 1'b1)
            $display("FAIL trig_capture state=%0d count=%0d valid=%b exp 2/1/1", state, count, bus.trc_valid);
        else passed++;
        checks++; if (bus.trc_pc !== 32'h10 || bus.trc_alu !== 32'hA5A5_0010)
            $display("FAIL trig_head pc=%h alu=%h exp 00000010/a5a50010", bus.trc_pc, bus.trc_alu);
        else passed++;
    endtask

    task automatic test_freeze();
        bus.trc_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            set_pc(32'h10 + 32'(4 * k)); step();
            if (k == 6) begin
                checks++; if (state !== 2'd2 || count !== 5'd7)
                    $display("FAIL freeze_pre state=%0d count=%0d exp 2/7", state, count);
                else passed++;
            end
        end
        checks++; if (state !== 2'd3 || count !== 5'd8)
            $display("FAIL freeze_full state=%0d count=%0d exp 3/8", state, count);
        else passed++;
        set_pc(32'h30); step();
        checks++; if (state !== 2'd3 || count !== 5'd8 || bus.trc_pc !== 32'h10)
            $display("FAIL freeze_hold state=%0d count=%0d head=%h exp 3/8/00000010", state, count, bus.trc_pc);
        else passed++;
        bus.trc_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.trc_pc !== 32'h10 + 32'(4 * i) || bus.trc_alu !== 32'hA5A5_0010 + 32'(4 * i))
                $display("FAIL freeze_drain%0d pc=%h alu=%h exp %h/%h", i, bus.trc_pc, bus.trc_alu,
                         32'h10 + 32'(4 * i), 32'hA5A5_0010 + 32'(4 * i));
            else passed++;
            step();
        end
        checks++; if (count !== 5'd0 || bus.trc_valid !== 1'b0 || state !== 2'd3)
            $display("FAIL freeze_empty count=%0d valid=%b state=%0d exp 0/0/3", count, bus.trc_valid, state);
        else passed++;
        bus.trc_ready = 1'b0; arm = 1'b0; step();
        checks++; if (state !== 2'd0)
            $display("FAIL freeze_disarm state=%0d exp 0", state);
        else passed++;
    endtask

    task automatic test_stall();
        arm = 1'b1; set_pc(32'h00); step();
        set_pc(32'h10); step();
        stall = 1'b1; set_pc(32'h14);
        step(); step(); step();
        checks++; if (count !== 5'd1 || stall_count !== 16'd3)
            $display("FAIL stall_hold count=%0d stall_count=%0d exp 1/3", count, stall_count);
        else passed++;
        stall = 1'b0; step();
        checks++; if (count !== 5'd2 || stall_count !== 16'd3 || bus.trc_pc !== 32'h10)
            $display("FAIL stall_resume count=%0d stall_count=%0d head=%h exp 2/3/00000010", count, stall_count, bus.trc_pc);
        else passed++;
        arm = 1'b0; step();
        checks++; if (state !== 2'd0 || count !== 5'd2 || stall_count !== 16'd3)
            $display("FAIL stall_retain state=%0d count=%0d stall_count=%0d exp 0/2/3", state, count, stall_count);
        else passed++;
        bus.trc_ready = 1'b1; step();
        checks++; if (bus.trc_pc !== 32'h14 || bus.trc_alu !== 32'hA5A5_0014 || count !== 5'd1)
            $display("FAIL stall_second pc=%h alu=%h count=%0d exp 00000014/a5a50014/1", bus.trc_pc, bus.trc_alu, count);
        else passed++;
        step();
        bus.trc_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        arm = 1'b1; set_pc(32'h00); step();
        checks++; if (state !== 2'd1 || stall_count !== 16'd0)
            $display("FAIL b2b_rearm state=%0d stall_count=%0d exp 1/0", state, stall_count);
        else passed++;
        bus.trc_ready = 1'b1;
        set_pc(32'h10); step();
        for (int i = 1; i <= 3; i++) begin
            set_pc(32'h10 + 32'(4 * i)); step();
            checks++; if (count !== 5'd1 || bus.trc_pc !== 32'h10 + 32'(4 * i) || bus.trc_alu !== 32'hA5A5_0010 + 32'(4 * i))
                $display("FAIL b2b_entry%0d count=%0d pc=%h alu=%h exp 1/%h/%h", i, count, bus.trc_pc, bus.trc_alu,
                         32'h10 + 32'(4 * i), 32'hA5A5_0010 + 32'(4 * i));
            else passed++;
        end
        arm = 1'b0; step();
        step();
        checks++; if (state !== 2'd0 || count !== 5'd0 || bus.trc_valid !== 1'b0)
            $display("FAIL b2b_empty_pop state=%0d count=%0d valid=%b exp 0/0/0", state, count, bus.trc_valid);
        else passed++;
        bus.trc_ready = 1'b0;
    endtask

    task automatic test_flags();
        logic [5:0] exp_f [4];
        exp_f[0] = 6'b000000; exp_f[1] = 6'b101001; exp_f[2] = 6'b100000; exp_f[3] = 6'b000011;
        arm = 1'b1; set_pc(32'h00); step();
        set_pc(32'h10); step();
        set_pc(32'h14); pcsrc = 1'b1; fwd_a = 2'b10; fwd_b = 2'b01; step();
        set_pc(32'h18); pcsrc = 1'b1; fwd_a = 2'b00; fwd_b = 2'b00; step();
        set_pc(32'h1C); pcsrc = 1'b0; fwd_b = 2'b11; step();
        fwd_b = 2'b00; arm = 1'b0; step();
        checks++; if (branch_count !== 16'd2 || count !== 5'd4)
            $display("FAIL flags_count branch_count=%0d count=%0d exp 2/4", branch_count, count);
        else passed++;
        bus.trc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.trc_flags !== exp_f[i] || bus.trc_pc !== 32'h10 + 32'(4 * i))
                $display("FAIL flags_entry%0d flags=%b pc=%h exp %b/%h", i, bus.trc_flags, bus.trc_pc,
                         exp_f[i], 32'h10 + 32'(4 * i));
            else passed++;
            step();
        end
        bus.trc_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        arm = 1'b1; set_pc(32'h00); step();
        for (int i = 0; i < 5; i++) begin
            set_pc(32'h10 + 32'(4 * i)); step();
        end
        checks++; if (state !== 2'd2 || count !== 5'd5)
            $display("FAIL rstmid_pre state=%0d count=%0d exp 2/5", state, count);
        else passed++;
        reset = 1'b0; step();
        checks++; if (state !== 2'd0 || count !== 5'd0 || bus.trc_valid !== 1'b0 || bus.trc_pc !== 32'h0)
            $display("FAIL rstmid_clear state=%0d count=%0d valid=%b pc=%h exp 0/0/0/0", state, count, bus.trc_valid, bus.trc_pc);
        else passed++;
        reset = 1'b1; set_pc(32'h24); step();
        checks++; if (state !== 2'd1 || count !== 5'd0)
            $display("FAIL rstmid_rearm state=%0d count=%0d exp 1/0", state, count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_freeze();
        test_stall();
        test_back_to_back();
        test_flags();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
